// File: rtl/cpr_seq_acc_if.sv
// rtl/cpr_seq_acc_if.sv - operand-beat input stream and resolved-sum output stream of cpr_seq_acc
interface cpr_seq_acc_if #(
    parameter int width = 16,
    parameter int lanes = 2,
    parameter int gbits = 4
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [lanes*width-1:0]   in_data_i;
    logic                     in_last_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [width+gbits-1:0]   out_sum_o;
    logic                     out_ovf_o;

    modport master (
        output in_valid_i, in_data_i, in_last_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_sum_o, out_ovf_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, out_ready_i,
        output in_ready_o, out_valid_o, out_sum_o, out_ovf_o
    );
endinterface

// File: rtl/cpr_seq_acc.sv
// rtl/cpr_seq_acc.sv - carry-save multi-operand accumulator; overflow reporting under CPR_SEQ_ACC_OVF_EN
// Each column uses one (m,2) compressor; carries leave a column only through cout_o/carry_o.
module cpr_seq_acc_cmp #(
    parameter int m     = 4,
    parameter int speed = 1
) (
    input  logic [m-1:0] x_i,
    input  logic [m-4:0] cin_i,
    output logic [m-4:0] cout_o,
    output logic         sum_o,
    output logic         carry_o
);
    logic [m-3:0] fc;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    generate
        if (speed == 0) begin : g_lin
            logic [m-3:0] acc;
            assign acc[0] = ^x_i[2:0];
            assign fc[0]  = maj3(x_i[0], x_i[1], x_i[2]);
            for (genvar i = 1; i <= m-3; i++) begin : g_fa
                assign acc[i] = acc[i-1] ^ x_i[i+2] ^ cin_i[i-1];
                assign fc[i]  = maj3(acc[i-1], x_i[i+2], cin_i[i-1]);
            end
            assign sum_o = acc[m-3];
        end else begin : g_tree
            // Bits are consumed in FIFO order, so operand pairs reduce in parallel
            // before the running sums meet; adder i only ever sees cin_i[i-1].
            logic [2*m-3:0] pool;
            assign pool[m-1:0] = x_i;
            assign pool[m]     = ^x_i[2:0];
            assign fc[0]       = maj3(x_i[0], x_i[1], x_i[2]);
            for (genvar i = 1; i <= m-3; i++) begin : g_fa
                assign pool[m+i] = pool[2*i+1] ^ pool[2*i+2] ^ cin_i[i-1];
                assign fc[i]     = maj3(pool[2*i+1], pool[2*i+2], cin_i[i-1]);
            end
            assign sum_o = pool[2*m-3];
        end
    endgenerate

    assign cout_o  = fc[m-4:0];
    assign carry_o = fc[m-3];
endmodule

module cpr_seq_acc #(
    parameter int width = 16,
    parameter int lanes = 2,
    parameter int gbits = 4,
    parameter int speed = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    cpr_seq_acc_if.slave bus
);
    localparam int owidth = width + gbits;
    localparam int m      = lanes + 2;
`ifdef CPR_SEQ_ACC_OVF_EN
    localparam int ncar   = owidth;
`else
    localparam int ncar   = owidth - 1;
`endif

    typedef enum logic [1:0] {ST_ACC, ST_RES, ST_OUT} state_e;

    state_e              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [owidth-1:0]   s_q, c_q, sum_q;
    logic [owidth-1:0]   s_d, c_d;
    logic [owidth-1:0]   col_sum;
    logic [ncar-1:0]     col_carry;
    logic [m-4:0]        col_cout [ncar];
    logic                in_hs;

    assign in_hs = bus.in_valid_i & in_ready_q;

    generate
        for (genvar j = 0; j < owidth; j++) begin : g_col
            logic [lanes-1:0] opb;
            logic [m-4:0]     cin;
            for (genvar k = 0; k < lanes; k++) begin : g_op
                if (j < width) begin : g_bit
                    assign opb[k] = bus.in_data_i[k*width+j];
                end else begin : g_ext
                    assign opb[k] = 1'b0;
                end
            end
            if (j == 0) begin : g_cin0
                assign cin = '0;
            end else begin : g_cinj
                assign cin = col_cout[j-1];
            end
            if (j < ncar) begin : g_cmp
                cpr_seq_acc_cmp #(.m(m), .speed(speed)) u_cmp (
                    .x_i     ({c_q[j], s_q[j], opb}),
                    .cin_i   (cin),
                    .cout_o  (col_cout[j]),
                    .sum_o   (col_sum[j]),
                    .carry_o (col_carry[j])
                );
            end else begin : g_par
                // Without overflow capture the top column only needs its parity.
                assign col_sum[j] = ^{c_q[j], s_q[j], opb, cin};
            end
        end
    endgenerate

    assign s_d = col_sum;
    assign c_d = {col_carry[owidth-2:0], 1'b0};

`ifdef CPR_SEQ_ACC_OVF_EN
    logic              drop;
    logic              sticky_q;
    logic              ovf_q;
    logic [owidth:0]   res;
    assign drop = col_carry[owidth-1] | (|col_cout[owidth-1]);
    assign res  = {1'b0, s_q} + {1'b0, c_q};
`else
    logic [owidth-1:0] res;
    assign res  = s_q + c_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= '0;
            sum_q       <= '0;
`ifdef CPR_SEQ_ACC_OVF_EN
            sticky_q    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_hs) begin
                        s_q <= s_d;
                        c_q <= c_d;
`ifdef CPR_SEQ_ACC_OVF_EN
                        sticky_q <= sticky_q | drop;
`endif
                        if (bus.in_last_i) begin
                            state_q    <= ST_RES;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                ST_RES: begin
                    sum_q <= res[owidth-1:0];
`ifdef CPR_SEQ_ACC_OVF_EN
                    ovf_q    <= sticky_q | res[owidth];
                    sticky_q <= 1'b0;
`endif
                    s_q         <= '0;
                    c_q         <= '0;
                    state_q     <= ST_OUT;
                    out_valid_q <= 1'b1;
                end
                ST_OUT: begin
                    if (bus.out_ready_i) begin
                        state_q     <= ST_ACC;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_sum_o   = sum_q;
`ifdef CPR_SEQ_ACC_OVF_EN
    assign bus.out_ovf_o   = ovf_q;
`else
    assign bus.out_ovf_o   = 1'b0;
`endif
endmodule

// File: tb/tb_cpr_seq_acc.sv
// tb/tb_cpr_seq_acc.sv - scoreboard bench driving linear and tree builds of cpr_seq_acc in lockstep
module tb_cpr_seq_acc;
    localparam int W  = 8;
    localparam int L  = 2;
    localparam int G  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        out_ready = 1'b0;
    logic        rnd_rdy = 1'b0;
    logic        rdy_set = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [12:0] exp_q [$];

    always #5 clk = ~clk;

    cpr_seq_acc_if #(.width(W), .lanes(L), .gbits(G)) bus0 (), bus1 ();

    assign bus0.in_valid_i  = in_valid;
    assign bus0.in_data_i   = in_data;
    assign bus0.in_last_i   = in_last;
    assign bus0.out_ready_i = out_ready;
    assign bus1.in_valid_i  = in_valid;
    assign bus1.in_data_i   = in_data;
    assign bus1.in_last_i   = in_last;
    assign bus1.out_ready_i = out_ready;

    cpr_seq_acc #(.width(W), .lanes(L), .gbits(G), .speed(0)) dut0 (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus0)
    );
    cpr_seq_acc #(.width(W), .lanes(L), .gbits(G), .speed(1)) dut1 (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int total);
        logic [12:0] v;
        v[11:0] = total[11:0];
`ifdef CPR_SEQ_ACC_OVF_EN
        v[12] = (total >= 4096);
`else
        v[12] = 1'b0;
`endif
        exp_q.push_back(v);
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_set;
    end

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid_o && out_ready) begin
            logic [12:0] e;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum_tree",  32'(bus1.out_sum_o),   32'(e[11:0]));
                check("ovf_tree",  32'(bus1.out_ovf_o),   32'(e[12]));
                check("sum_lin",   32'(bus0.out_sum_o),   32'(e[11:0]));
                check("ovf_lin",   32'(bus0.out_ovf_o),   32'(e[12]));
                check("valid_lin", 32'(bus0.out_valid_o), 32'd1);
            end
        end
    end

    task automatic send_beat(input logic [15:0] d, input logic l, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waits    = 0;
        @(negedge clk);
        while (!bus1.in_ready_o && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 200) check("beat_accept", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit rnd, input logic [15:0] fixed);
        logic [15:0] beats [20];
        int total;
        int w;
        total = 0;
        for (int i = 0; i < n; i++) begin
            if (!rnd)                          beats[i] = fixed;
            else if ($urandom_range(0, 1) != 0) beats[i] = 16'hFFFF ^ 16'($urandom_range(0, 255));
            else                               beats[i] = 16'($urandom_range(0, 65535));
            total += int'(beats[i][15:8]) + int'(beats[i][7:0]);
        end
        push_exp(total);
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(beats[i], (i == n-1), w);
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int c;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus1.in_ready_o),  32'd1);
        check("rst_out_valid", 32'(bus1.out_valid_o), 32'd0);
        check("rst_sum",       32'(bus1.out_sum_o),   32'd0);
        check("rst_ovf",       32'(bus1.out_ovf_o),   32'd0);
        rst_n   = 1'b1;
        rdy_set = 1'b1;
        @(posedge clk);
        #1;

        // single beat and result latency
        push_exp(8);
        in_valid = 1'b1;
        in_data  = 16'h0305;
        in_last  = 1'b1;
        @(negedge clk);
        check("t1_ready", 32'(bus1.in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("t1_res_valid", 32'(bus1.out_valid_o), 32'd0);
        check("t1_res_ready", 32'(bus1.in_ready_o),  32'd0);
        @(negedge clk);
        check("t1_valid", 32'(bus1.out_valid_o), 32'd1);
        check("t1_sum",   32'(bus1.out_sum_o),   32'h008);
        wait_drain();

        // four full beats back to back
        push_exp(4 * 510);
        for (int i = 0; i < 4; i++) begin
            send_beat(16'hFFFF, (i == 3), w);
            check("t2_no_bubble", 32'(w), 32'd0);
        end
        wait_drain();

        // overflow: 9 x 510 = 4590
        send_pkt(9, 1'b0, 16'hFFFF);
        wait_drain();

        // output backpressure with a held input beat
        rdy_set = 1'b0;
        @(posedge clk);
        #1;
        send_pkt(1, 1'b0, 16'h1020);
        in_valid = 1'b1;
        in_data  = 16'h0102;
        in_last  = 1'b1;
        push_exp(3);
        c = 0;
        @(negedge clk);
        while (!bus1.out_valid_o && c < 10) begin
            c++;
            @(negedge clk);
        end
        check("t4_valid_seen", 32'(bus1.out_valid_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(bus1.out_valid_o), 32'd1);
            check("t4_hold_sum",   32'(bus1.out_sum_o),   32'h030);
            check("t4_hold_ovf",   32'(bus1.out_ovf_o),   32'd0);
            check("t4_hold_ready", 32'(bus1.in_ready_o),  32'd0);
            @(negedge clk);
        end
        rdy_set = 1'b1;
        send_beat(16'h0102, 1'b1, w);
        wait_drain();

        // reset in the middle of a packet
        send_beat(16'hFFFF, 1'b0, w);
        send_beat(16'hFFFF, 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready",  32'(bus1.in_ready_o),  32'd1);
        check("t5_rst_out_valid", 32'(bus1.out_valid_o), 32'd0);
        check("t5_rst_sum",       32'(bus1.out_sum_o),   32'd0);
        check("t5_rst_ovf",       32'(bus1.out_ovf_o),   32'd0);
        check("t5_rst_sum_lin",   32'(bus0.out_sum_o),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_pkt(1, 1'b0, 16'h0101);
        wait_drain();

        // random packets with random valid gaps and output stalls
        rnd_rdy = 1'b1;
        for (int p = 0; p < 30; p++) begin
            send_pkt($urandom_range(1, 20), 1'b1, 16'h0);
        end
        rnd_rdy = 1'b0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
